// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and tn/rwd load transform.
// Define PIPE_SKID_EN to add one skid entry behind the output register, which makes in_ready a registered signal.
module pipe_stage_reg #(
    parameter int DW  = 32,
    parameter int SW  = 106,
    parameter int TNW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [SW-1:0]  in_side,
    input  logic [DW-1:0]  in_ar,
    input  logic [DW-1:0]  in_rwd,
    input  logic [TNW-1:0] in_tn,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_side,
    output logic [DW-1:0]  out_ar,
    output logic [DW-1:0]  out_rwd,
    output logic [TNW-1:0] out_tn
);

    logic           r_out_valid;
    logic [SW-1:0]  r_out_side;
    logic [DW-1:0]  r_out_ar;
    logic [DW-1:0]  r_out_rwd;
    logic [TNW-1:0] r_out_tn;

    logic           w_in_xfer;
    logic           w_out_xfer;
    logic           w_out_free;
    logic           w_out_load;
    logic           w_out_valid_next;

    logic [TNW-1:0] w_ld_tn;
    logic [DW-1:0]  w_ld_rwd;

    logic [SW-1:0]  w_src_side;
    logic [DW-1:0]  w_src_ar;
    logic [DW-1:0]  w_src_rwd;
    logic [TNW-1:0] w_src_tn;

    // Transform applied once, at the moment an instruction enters stage storage.
    assign w_ld_tn  = (in_tn == '0) ? '0 : (in_tn - TNW'(1));
    assign w_ld_rwd = (in_tn == TNW'(1)) ? in_ar : in_rwd;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_out_free = !r_out_valid || out_ready;

`ifdef PIPE_SKID_EN
    logic           r_skid_valid;
    logic [SW-1:0]  r_skid_side;
    logic [DW-1:0]  r_skid_ar;
    logic [DW-1:0]  r_skid_rwd;
    logic [TNW-1:0] r_skid_tn;

    logic           w_skid_load;
    logic           w_skid_valid_next;

    assign in_ready = !r_skid_valid;

    // A held skid entry has priority into the output; no input is accepted while it exists.
    assign w_out_load  = !flush && (r_skid_valid ? w_out_free : (w_in_xfer && w_out_free));
    assign w_skid_load = !flush && !r_skid_valid && w_in_xfer && !w_out_free;

    always_comb begin
        w_src_side = in_side;
        w_src_ar   = in_ar;
        w_src_rwd  = w_ld_rwd;
        w_src_tn   = w_ld_tn;
        if (r_skid_valid) begin
            w_src_side = r_skid_side;
            w_src_ar   = r_skid_ar;
            w_src_rwd  = r_skid_rwd;
            w_src_tn   = r_skid_tn;
        end
    end

    always_comb begin
        w_skid_valid_next = r_skid_valid;
        if (flush) begin
            w_skid_valid_next = 1'b0;
        end else if (w_skid_load) begin
            w_skid_valid_next = 1'b1;
        end else if (r_skid_valid && w_out_free) begin
            w_skid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_valid <= 1'b0;
            r_skid_side  <= '0;
            r_skid_ar    <= '0;
            r_skid_rwd   <= '0;
            r_skid_tn    <= '0;
        end else begin
            r_skid_valid <= w_skid_valid_next;
            if (w_skid_load) begin
                r_skid_side <= in_side;
                r_skid_ar   <= in_ar;
                r_skid_rwd  <= w_ld_rwd;
                r_skid_tn   <= w_ld_tn;
            end
        end
    end
`else
    assign in_ready   = w_out_free;
    assign w_out_load = !flush && w_in_xfer;

    assign w_src_side = in_side;
    assign w_src_ar   = in_ar;
    assign w_src_rwd  = w_ld_rwd;
    assign w_src_tn   = w_ld_tn;
`endif

    // Flush wins; a load replaces a draining entry in the same edge with no bubble.
    always_comb begin
        w_out_valid_next = r_out_valid;
        if (flush) begin
            w_out_valid_next = 1'b0;
        end else if (w_out_load) begin
            w_out_valid_next = 1'b1;
        end else if (w_out_xfer) begin
            w_out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_side  <= '0;
            r_out_ar    <= '0;
            r_out_rwd   <= '0;
            r_out_tn    <= '0;
        end else begin
            r_out_valid <= w_out_valid_next;
            if (w_out_load) begin
                r_out_side <= w_src_side;
                r_out_ar   <= w_src_ar;
                r_out_rwd  <= w_src_rwd;
                r_out_tn   <= w_src_tn;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_side  = r_out_side;
    assign out_ar    = r_out_ar;
    assign out_rwd   = r_out_rwd;
    assign out_tn    = r_out_tn;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a FIFO-of-entries reference model.
module tb_pipe_stage_reg;
    localparam int DW  = 32;
    localparam int SW  = 106;
    localparam int TNW = 2;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [SW-1:0]  side;
        logic [DW-1:0]  ar;
        logic [DW-1:0]  rwd;
        logic [TNW-1:0] tn;
    } ent_t;

    logic           clk;
    logic           reset;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [SW-1:0]  in_side;
    logic [DW-1:0]  in_ar;
    logic [DW-1:0]  in_rwd;
    logic [TNW-1:0] in_tn;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_side;
    logic [DW-1:0]  out_ar;
    logic [DW-1:0]  out_rwd;
    logic [TNW-1:0] out_tn;

    int n_cmp = 0;
    int n_err = 0;
    ent_t q[$];

    pipe_stage_reg #(.DW(DW), .SW(SW), .TNW(TNW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_side(in_side), .in_ar(in_ar), .in_rwd(in_rwd), .in_tn(in_tn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_side(out_side), .out_ar(out_ar), .out_rwd(out_rwd), .out_tn(out_tn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t xform(input logic [SW-1:0] s, input logic [DW-1:0] a,
                                   input logic [DW-1:0] r, input logic [TNW-1:0] t);
        ent_t e;
        e.side = s;
        e.ar   = a;
        e.tn   = (t == 0) ? '0 : TNW'(int'(t) - 1);
        e.rwd  = (int'(t) == 1) ? a : r;
        return e;
    endfunction

    // Stage accepts while it has room, or (without skid) when the held entry leaves this cycle.
    function automatic bit model_ready(input logic ordy);
`ifdef PIPE_SKID_EN
        return q.size() < CAP;
`else
        return (q.size() < CAP) || ordy;
`endif
    endfunction

    // One clock cycle: drive at negedge, check at negedge+1, advance model at the posedge, return at posedge+1.
    task automatic step(input logic v, input logic [SW-1:0] s, input logic [DW-1:0] a,
                        input logic [DW-1:0] r, input logic [TNW-1:0] t,
                        input logic ordy, input logic fl);
        bit exp_rdy, ixf, oxf;
        @(negedge clk);
        in_valid = v; in_side = s; in_ar = a; in_rwd = r; in_tn = t;
        out_ready = ordy; flush = fl;
        #1;
        exp_rdy = model_ready(ordy);
        check_eq("in_ready", 128'(in_ready), 128'(exp_rdy));
        check_eq("out_valid", 128'(out_valid), 128'(q.size() > 0));
        if (q.size() > 0) begin
            check_eq("out_side", 128'(out_side), 128'(q[0].side));
            check_eq("out_ar", 128'(out_ar), 128'(q[0].ar));
            check_eq("out_rwd", 128'(out_rwd), 128'(q[0].rwd));
            check_eq("out_tn", 128'(out_tn), 128'(q[0].tn));
        end
        ixf = v && exp_rdy;
        oxf = (q.size() > 0) && ordy;
        if (oxf && !fl)
            $display("xfer out ar=0x%08h rwd=0x%08h tn=%0d", q[0].ar, q[0].rwd, q[0].tn);
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (oxf) void'(q.pop_front());
            if (ixf) q.push_back(xform(s, a, r, t));
        end
    endtask

    function automatic logic [SW-1:0] rnd_side();
        logic [127:0] tmp;
        tmp = {$urandom(), $urandom(), $urandom(), $urandom()};
        return tmp[SW-1:0];
    endfunction

    logic [SW-1:0]  snap_side;
    logic [DW-1:0]  snap_ar, snap_rwd;
    logic [TNW-1:0] snap_tn;

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_side = '0; in_ar = '0; in_rwd = '0; in_tn = '0;
        #1;
        check_eq("rst_valid", 128'(out_valid), 128'(0));
        check_eq("rst_ready", 128'(in_ready), 128'(1));
        check_eq("rst_side", 128'(out_side), 128'(0));
        check_eq("rst_ar", 128'(out_ar), 128'(0));
        check_eq("rst_rwd", 128'(out_rwd), 128'(0));
        check_eq("rst_tn", 128'(out_tn), 128'(0));
        @(negedge clk);
        reset = 1'b1;

        // Transform cases: countdown, capture at tn==1, saturation at tn==0.
        step(1'b1, rnd_side(), 32'h11, 32'h22, 2'd2, 1'b1, 1'b0);
        check_eq("tp1_valid", 128'(out_valid), 128'(1));
        check_eq("tp1_tn", 128'(out_tn), 128'(1));
        check_eq("tp1_rwd", 128'(out_rwd), 128'(32'h22));
        step(1'b1, rnd_side(), 32'hDEADBEEF, 32'h0, 2'd1, 1'b1, 1'b0);
        check_eq("tp2_rwd", 128'(out_rwd), 128'(32'hDEADBEEF));
        check_eq("tp2_tn", 128'(out_tn), 128'(0));
        step(1'b1, rnd_side(), 32'h44, 32'h33, 2'd0, 1'b1, 1'b0);
        check_eq("tp3_tn", 128'(out_tn), 128'(0));
        check_eq("tp3_rwd", 128'(out_rwd), 128'(32'h33));

        // Stall with a second instruction offered.
        step(1'b1, rnd_side(), 32'hA1, 32'hA2, 2'd3, 1'b1, 1'b0);
        snap_side = out_side; snap_ar = out_ar; snap_rwd = out_rwd; snap_tn = out_tn;
        check_eq("ld_tn", 128'(snap_tn), 128'(2));
        for (int k = 0; k < 5; k++) begin
            step(1'b1, rnd_side(), 32'hB1, 32'hB2, 2'd1, 1'b0, 1'b0);
            check_eq("stall_side", 128'(out_side), 128'(snap_side));
            check_eq("stall_ar", 128'(out_ar), 128'(snap_ar));
            check_eq("stall_rwd", 128'(out_rwd), 128'(snap_rwd));
            check_eq("stall_tn", 128'(out_tn), 128'(snap_tn));
            check_eq("stall_rdy", 128'(in_ready), 128'(0));
        end
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
        check_eq("drained", 128'(out_valid), 128'(0));

        // Flush with storage full and an input offered.
        step(1'b1, rnd_side(), 32'hC1, 32'hC2, 2'd2, 1'b0, 1'b0);
        step(1'b1, rnd_side(), 32'hC3, 32'hC4, 2'd2, 1'b0, 1'b0);
        step(1'b1, rnd_side(), 32'hC5, 32'hC6, 2'd2, 1'b0, 1'b1);
        check_eq("flush_valid", 128'(out_valid), 128'(0));
        check_eq("flush_ready", 128'(in_ready), 128'(1));
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
            check_eq("post_flush_v", 128'(out_valid), 128'(0));
        end

        // Back-to-back stream: one output per cycle, in order.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, rnd_side(), 32'(100 + k), 32'(200 + k), 2'd2, 1'b1, 1'b0);
            check_eq("stream_v", 128'(out_valid), 128'(1));
            check_eq("stream_ar", 128'(out_ar), 128'(100 + k));
        end
        step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges while stalled.
        step(1'b1, rnd_side(), 32'hE1, 32'hE2, 2'd2, 1'b0, 1'b0);
        step(1'b1, rnd_side(), 32'hE3, 32'hE4, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_valid", 128'(out_valid), 128'(0));
        check_eq("arst_ready", 128'(in_ready), 128'(1));
        check_eq("arst_side", 128'(out_side), 128'(0));
        check_eq("arst_ar", 128'(out_ar), 128'(0));
        check_eq("arst_rwd", 128'(out_rwd), 128'(0));
        check_eq("arst_tn", 128'(out_tn), 128'(0));
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 4) != 0, rnd_side(), $urandom(), $urandom(),
                 TNW'($urandom_range(0, (1 << TNW) - 1)),
                 ($urandom % 3) != 0, ($urandom % 32) == 0);
        end
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the CPU datapath, generalising the fixed E/M latch into a reusable stage boundary (E/M, M/W and beyond). Carries a caller-packed sideband payload plus the forwarding fields: a result word, a write-data word, and a "time-to-new" countdown. Adds valid/ready flow control, synchronous flush to bubble, and an optional skid buffer. It sits between any two pipeline stages. Producers drive the `in_*` side and the next stage consumes the `out_*` side.

## Interface
- `DW`, 32, width of `ar` and `rwd` data words
- `SW`, 106, width of opaque sideband payload (pc, ins, rwa, rd2, exec, bd packed by caller)
- `TNW`, 2, width of the time-to-new counter; `TNW` ≥ 1
- `clk` input 1: clock, all state updates on rising edge
- `reset` input 1: asynchronous, active-low reset
- `flush` input 1: synchronous kill of all held contents
- `in_valid` input 1: producer presents an instruction
- `in_ready` output 1: stage accepts the input this cycle
- `in_side` input SW: sideband payload
- `in_ar` input DW: ALU/HILO result of the producing stage
- `in_rwd` input DW: register write data known so far
- `in_tn` input TNW: stages remaining until the result is available
- `out_valid` output 1: output holds a live instruction
- `out_ready` input 1: consumer takes the output this cycle
- `out_side` output SW: latched sideband payload
- `out_ar` output DW: latched result
- `out_rwd` output DW: latched write data, after the tn capture rule
- `out_tn` output TNW: latched countdown, after the decrement rule

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Load transform, applied exactly once per instruction when the instruction is written into stage storage:
  - `tn' = (in_tn == 0) ? 0 : in_tn - 1`, which saturates at 0.
  - `rwd' = (in_tn == 1) ? in_ar : in_rwd`.
  - `side` and `ar` are copied unchanged.
- Held entries never re-apply the transform. `tn` counts stages, not cycles.
- Stall: while `out_valid && !out_ready`, all `out_*` hold their values bit-exact.
- Bubble: when no valid entry is present, `out_valid` = 0. Payload outputs then hold their last value and must be ignored.
- Flush has priority over all other events:
  - At the edge, `out_valid` and every storage valid bit go to 0.
  - An input transferring in the same cycle is dropped.
  - Payload registers are not cleared.
  - `in_ready` after a flush is 1.
- Width rule: `TNW` = 1 gives `tn'` = 0 always, and the capture rule fires when `in_tn` = 1.

## Timing
- Reset (async assert, sync release): `out_valid` = 0, `out_side`/`out_ar`/`out_rwd`/`out_tn` = 0, skid entry empty, `in_ready` = 1.
- Reset asserted mid-stall discards all contents immediately; no clock edge is needed.
- Latency: 1 cycle from input transfer to `out_valid` when the output is empty or draining.
- Throughput: 1 instruction per cycle with `out_ready` held at 1.
- Simultaneous transfer in and out on a full output register: the new entry replaces the old one at the same edge with no bubble.

## Configuration
- Macro: `PIPE_SKID_EN`.
- Defined:
  - One extra entry (skid) behind the output register.
  - `in_ready` is a registered signal: `!skid_valid`.
  - An input arriving while the output is stalled is stored into skid with the transform applied.
  - When the output drains, skid moves to the output the next edge, untransformed.
  - With skid full, `in_ready` = 0.
  - No combinational path from `out_ready` to `in_ready`.
- Undefined:
  - No skid entry.
  - `in_ready = !out_valid || out_ready`, which is combinational.
  - Behaviour is otherwise identical.

## Test plan
- Reset release, then `in_valid`=1, `in_tn`=2, `in_ar`=0x11, `in_rwd`=0x22, `out_ready`=1 -> next cycle `out_valid`=1, `out_tn`=1, `out_rwd`=0x22.
- `in_tn`=1, `in_ar`=0xDEADBEEF, `in_rwd`=0 -> `out_rwd`=0xDEADBEEF, `out_tn`=0. Then `in_tn`=0 -> `out_tn`=0 (no wrap), `out_rwd`=`in_rwd`.
- Load an entry, then `out_ready`=0 for 5 cycles -> outputs bit-stable for all 5 cycles, `out_tn` unchanged.
  - With `PIPE_SKID_EN`: a second input is accepted, then `in_ready`=0.
  - Without `PIPE_SKID_EN`: `in_ready`=0 immediately.
  - On `out_ready`=1, both entries emerge in order.
- `flush`=1 with the output and skid full and `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1, nothing emerges afterwards.
- Stream 8 back-to-back instructions with `out_ready`=1 -> 8 consecutive valid outputs, in order, no bubbles.
- Drive `reset`=0 asynchronously mid-stall, between edges -> all outputs 0 and `in_ready`=1 before the next clock edge.
